// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: round-robin grant, one transaction at a time,
// IDLE -> ACCESS -> RESP with configurable read latency and misalignment rejection.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  // Handshake: a requester raises req[i] and holds it (with we/addr/wdata) until
  // ack[i] pulses for one cycle; inputs are captured once at grant, so later
  // changes or an early drop of req do not affect the transaction in flight.

  logic [1:0]        r_state;
  logic              r_grant;
  logic              r_last_grant;
  logic              r_we;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [2:0]        r_cnt;

  logic              w_gnt;
  logic              w_we_sel;
  logic [ADDR_W-1:0] w_addr_sel;
  logic [DATA_W-1:0] w_wdata_sel;
  logic              w_misaligned;
  logic              w_access;
  logic              w_last_rd;

  // On contention the requester that was not served last wins.
  always_comb begin
    w_gnt = req[1];
    if (req == 2'b11) begin
      w_gnt = ~r_last_grant;
    end
  end

  assign w_we_sel     = w_gnt ? we[1]  : we[0];
  assign w_addr_sel   = w_gnt ? addr1  : addr0;
  assign w_wdata_sel  = w_gnt ? wdata1 : wdata0;
  assign w_misaligned = (w_addr_sel[1:0] != 2'b00);
  assign w_last_rd    = (r_cnt == 3'(RD_LAT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_cnt        <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_grant <= w_gnt;
            r_we    <= w_we_sel;
            r_addr  <= w_addr_sel;
            r_wdata <= w_wdata_sel;
            r_err   <= w_misaligned;
            r_cnt   <= 3'd0;
            r_state <= w_misaligned ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          if (r_we || w_last_rd) begin
            if (!r_we) begin
              r_rdata <= mem_rdata;
            end
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        RESP: begin
          r_last_grant <= r_grant;
          r_err        <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory strobes decode straight from state so reset removes them at once.
  assign w_access  = (r_state == ACCESS);
  assign mem_addr  = w_access ? r_addr  : '0;
  assign mem_wdata = w_access ? r_wdata : '0;
  assign MemWrite  = w_access & r_we;
  assign MemRead   = w_access & ~r_we;

  assign ack       = (r_state == RESP) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign err       = (r_state == RESP) & r_err;
  assign rdata     = r_rdata;
  assign busy      = (r_state != IDLE);
  assign state_dbg = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one RD_LAT=1 instance with a word memory model,
// one RD_LAT=3 instance with an address-derived read pattern.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;

  logic [1:0]  req, we, ack, state_dbg;
  logic [31:0] addr0, addr1, wdata0, wdata1, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        err, busy, MemWrite, MemRead;

  logic [1:0]  req3, we3, ack3, state_dbg3;
  logic [31:0] addr3_0, rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic        err3, busy3, MemWrite3, MemRead3;

  logic [31:0] mem [0:15];
  logic [1:0]  exp_q[$];
  logic [1:0]  exp_ack;

  int n_chk;
  int n_pass;
  int n_fail;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .MemWrite(MemWrite), .MemRead(MemRead),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .we(we3),
    .addr0(addr3_0), .addr1(32'h0), .wdata0(32'h0), .wdata1(32'h0),
    .ack(ack3), .err(err3), .rdata(rdata3), .busy(busy3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .MemWrite(MemWrite3), .MemRead(MemRead3),
    .mem_rdata(mem_rdata3), .state_dbg(state_dbg3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (MemWrite) mem[mem_addr[5:2]] <= mem_wdata;
  end
  assign mem_rdata  = mem[mem_addr[5:2]];
  assign mem_rdata3 = mem_addr3 ^ 32'hA5A5_0000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst = 1'b0; req = 2'b00; we = 2'b00;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    req3 = 2'b00; we3 = 2'b00; addr3_0 = 0;

    // reset state
    tick(); tick();
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_memrd", MemRead, 0);
    check("rst_memwr", MemWrite, 0);
    check("rst_rdata", rdata, 0);
    check("rst_maddr", mem_addr, 0);
    check("rst_mwdata", mem_wdata, 0);
    check("rst_state", state_dbg, 0);

    // write 69 to address 4
    rst = 1'b1;
    req = 2'b01; we = 2'b01; addr0 = 4; wdata0 = 69;
    tick();
    check("wr_memwr", MemWrite, 1);
    check("wr_memrd", MemRead, 0);
    check("wr_maddr", mem_addr, 4);
    check("wr_mwdata", mem_wdata, 69);
    check("wr_ack_early", ack, 0);
    check("wr_busy", busy, 1);
    tick();
    check("wr_ack", ack, 2'b01);
    check("wr_err", err, 0);
    check("wr_memwr_off", MemWrite, 0);
    req = 2'b00;
    tick();
    check("wr_idle_ack", ack, 0);
    check("wr_idle_busy", busy, 0);
    check("wr_mem", mem[1], 69);

    // read it back
    req = 2'b01; we = 2'b00; addr0 = 4;
    tick();
    check("rd_memrd", MemRead, 1);
    check("rd_maddr", mem_addr, 4);
    check("rd_ack_early", ack, 0);
    tick();
    check("rd_ack", ack, 2'b01);
    check("rd_rdata", rdata, 69);
    check("rd_err", err, 0);
    req = 2'b00;
    tick();

    // reset in the middle of a read
    req = 2'b01; we = 2'b00; addr0 = 4;
    tick();
    check("rr_memrd", MemRead, 1);
    rst = 1'b0; req = 2'b00;
    #1;
    check("rr_memrd_async", MemRead, 0);
    check("rr_busy", busy, 0);
    check("rr_rdata", rdata, 0);
    check("rr_ack", ack, 0);
    tick();
    check("rr_ack_hold", ack, 0);
    rst = 1'b1;
    req = 2'b01; we = 2'b00; addr0 = 4;
    tick();
    check("rr2_memrd", MemRead, 1);
    tick();
    check("rr2_ack", ack, 2'b01);
    check("rr2_rdata", rdata, 69);
    req = 2'b00;

    // contention from reset: grants 0,1,0,1
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
    req = 2'b11; we = 2'b11;
    addr0 = 16; addr1 = 20; wdata0 = 32'hAAAA; wdata1 = 32'hBBBB;
    exp_q = {2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 1; i <= 11; i++) begin
      tick();
      check("ct_both_ack", (ack == 2'b11), 0);
      if (ack != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("ct_extra_ack", ack, 0);
        end else begin
          exp_ack = exp_q.pop_front();
          check("ct_grant", ack, exp_ack);
        end
      end
    end
    check("ct_all_acked", exp_q.size(), 0);
    check("ct_mem0", mem[4], 32'hAAAA);
    check("ct_mem1", mem[5], 32'hBBBB);
    req = 2'b00;
    tick();

    // misaligned read from requester 1
    req = 2'b10; we = 2'b00; addr1 = 6;
    tick();
    check("mis_ack", ack, 2'b10);
    check("mis_err", err, 1);
    check("mis_memrd", MemRead, 0);
    check("mis_memwr", MemWrite, 0);
    check("mis_rdata", rdata, 0);
    req = 2'b00;
    tick();
    check("mis_ack_off", ack, 0);
    check("mis_err_off", err, 0);
    check("mis_busy", busy, 0);

    // request dropped after one cycle still completes
    req = 2'b01; we = 2'b01; addr0 = 12; wdata0 = 32'h1234;
    tick();
    check("drop_memwr", MemWrite, 1);
    check("drop_maddr", mem_addr, 12);
    req = 2'b00; addr0 = 32'h99; wdata0 = 32'hDEAD;
    tick();
    check("drop_ack", ack, 2'b01);
    check("drop_state", state_dbg, 2);
    tick();
    check("drop_busy", busy, 0);
    check("drop_ack_off", ack, 0);
    check("drop_mem", mem[3], 32'h1234);

    // RD_LAT=3 read of address 8; address input changes mid-access
    req3 = 2'b01; we3 = 2'b00; addr3_0 = 8;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("l3_memrd", MemRead3, 1);
      check("l3_maddr", mem_addr3, 8);
      check("l3_ack_early", ack3, 0);
      addr3_0 = 32'h40;
    end
    tick();
    check("l3_ack", ack3, 2'b01);
    check("l3_memrd_off", MemRead3, 0);
    check("l3_rdata", rdata3, 32'hA5A5_0008);
    req3 = 2'b00;
    tick();
    check("l3_busy", busy3, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
